// File: rtl/pwm_capture_if.sv
// Measurement bus for pwm_capture: the raw PWM input plus the captured results.
`timescale 1ns/1ps
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  // Capture block: samples pwm_in, drives the results.
  modport master (
    input  pwm_in,
    output high_cnt,
    output period_cnt,
    output meas_valid,
    output stuck_high,
    output stuck_low
  );

  // Consumer side: sources pwm_in, reads the results.
  modport slave (
    output pwm_in,
    input  high_cnt,
    input  period_cnt,
    input  meas_valid,
    input  stuck_high,
    input  stuck_low
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with stuck-input detection.
// The input is synchronized (2 flops) and delayed once more for edge detection.
// Rise and fall see identical latency, so measured widths are unbiased.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.master  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             s_q;
  logic             sd_q;
  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] r_d;
  logic [CNT_W-1:0] high_latch_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic             meas_valid_q;
  logic             stuck_high_q;
  logic             stuck_low_q;
  logic             rise_c;
  logic             fall_c;
  logic             timeout_c;

  // Edge events and the next run-counter value (restart on rise, saturate at TIMEOUT).
  always_comb begin
    rise_c    = s_q & ~sd_q;
    fall_c    = ~s_q & sd_q;
    r_d       = r_q;
    if (rise_c) begin
      r_d = ONE_C;
    end else if (r_q != TIMEOUT_C) begin
      r_d = r_q + ONE_C;
    end
    timeout_c = (r_d == TIMEOUT_C);
  end

  // Synchronizer, run counter, measurement FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      sd_q         <= 1'b0;
      r_q          <= '0;
      high_latch_q <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      sync1_q      <= bus.pwm_in;
      s_q          <= sync1_q;
      sd_q         <= s_q;
      r_q          <= r_d;
      meas_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (rise_c) begin
            state_q <= HIGH;
          end else if (timeout_c) begin
            state_q      <= STUCK;
            stuck_high_q <= s_q;
            stuck_low_q  <= ~s_q;
          end
        end
        HIGH: begin
          if (fall_c) begin
            state_q      <= LOW;
            high_latch_q <= r_q;
          end else if (timeout_c) begin
            state_q      <= STUCK;
            stuck_high_q <= s_q;
            stuck_low_q  <= ~s_q;
          end
        end
        LOW: begin
          if (rise_c) begin
            state_q <= HIGH;
            // A saturated counter means the period is not a valid measurement.
            if (r_q != TIMEOUT_C) begin
              period_cnt_q <= r_q;
              high_cnt_q   <= high_latch_q;
              meas_valid_q <= 1'b1;
            end
          end else if (timeout_c) begin
            state_q      <= STUCK;
            stuck_high_q <= s_q;
            stuck_low_q  <= ~s_q;
          end
        end
        STUCK: begin
          // First period after a stall is incomplete: resync without a strobe.
          if (rise_c) begin
            state_q      <= HIGH;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
          end else if (fall_c) begin
            state_q      <= LOW;
            stuck_high_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stuck_high = stuck_high_q;
  assign bus.stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (TIMEOUT=100 build).
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Strobe / flag monitor sampled on the falling edge.
  int               cyc             = 0;
  int               strobe_cnt      = 0;
  int               last_strobe_cyc = 0;
  int               last_gap        = 0;
  logic [CNT_W-1:0] last_high       = '0;
  logic [CNT_W-1:0] last_period     = '0;
  logic             saw_sl          = 1'b0;
  logic             saw_sh          = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.meas_valid === 1'b1) begin
      strobe_cnt      = strobe_cnt + 1;
      last_gap        = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      last_high       = bus.high_cnt;
      last_period     = bus.period_cnt;
    end
    if (bus.stuck_low === 1'b1)  saw_sl = 1'b1;
    if (bus.stuck_high === 1'b1) saw_sh = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    bus.pwm_in = v;
    step(n);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  function automatic logic [2*CNT_W+2:0] all_out();
    return {bus.high_cnt, bus.period_cnt, bus.meas_valid, bus.stuck_high, bus.stuck_low};
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    step(2);
    n_cmp++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_out());
    end
    rst = 1'b0;
    step(5);
    n_cmp++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL idle_outputs: got %h want 0", all_out());
    end
  endtask

  task automatic test_period_10_20();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    repeat (4) begin
      drive(1'b1, 10);
      drive(1'b0, 20);
    end
    drive(1'b1, 6);
    n_cmp++;
    if (strobe_cnt - s0 !== 4) begin
      n_err++; $display("FAIL p10_20_strobes: got %0d want 4", strobe_cnt - s0);
    end
    n_cmp++;
    if (last_high !== 16'd10) begin
      n_err++; $display("FAIL p10_20_high: got %0d want 10", last_high);
    end
    n_cmp++;
    if (last_period !== 16'd30) begin
      n_err++; $display("FAIL p10_20_period: got %0d want 30", last_period);
    end
    n_cmp++;
    if (last_gap !== 30) begin
      n_err++; $display("FAIL p10_20_gap: got %0d want 30", last_gap);
    end
    n_cmp++;
    if (bus.meas_valid !== 1'b0) begin
      n_err++; $display("FAIL p10_20_strobe_width: got %0b want 0", bus.meas_valid);
    end
  endtask

  task automatic test_min_pulse();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 9);
    drive(1'b1, 1);
    drive(1'b0, 9);
    drive(1'b1, 5);
    n_cmp++;
    if (strobe_cnt - s0 !== 2) begin
      n_err++; $display("FAIL min_pulse_strobes: got %0d want 2", strobe_cnt - s0);
    end
    n_cmp++;
    if (last_high !== 16'd1) begin
      n_err++; $display("FAIL min_pulse_high: got %0d want 1", last_high);
    end
    n_cmp++;
    if (last_period !== 16'd10) begin
      n_err++; $display("FAIL min_pulse_period: got %0d want 10", last_period);
    end
  endtask

  task automatic test_stuck_high();
    int s0;
    do_reset();
    drive(1'b0, 5);
    s0 = strobe_cnt;
    drive(1'b1, 120);
    n_cmp++;
    if (bus.stuck_high !== 1'b1) begin
      n_err++; $display("FAIL stuck_high_set: got %0b want 1", bus.stuck_high);
    end
    n_cmp++;
    if (bus.stuck_low !== 1'b0) begin
      n_err++; $display("FAIL stuck_high_low_flag: got %0b want 0", bus.stuck_low);
    end
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin
      n_err++; $display("FAIL stuck_high_no_strobe: got %0d want 0", strobe_cnt - s0);
    end
    drive(1'b0, 5);
    n_cmp++;
    if (bus.stuck_high !== 1'b0) begin
      n_err++; $display("FAIL stuck_high_clear: got %0b want 0", bus.stuck_high);
    end
    drive(1'b0, 10);
    s0 = strobe_cnt;
    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 6);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin
      n_err++; $display("FAIL stuck_high_recover_strobes: got %0d want 1", strobe_cnt - s0);
    end
    n_cmp++;
    if ({last_high, last_period} !== {16'd10, 16'd30}) begin
      n_err++; $display("FAIL stuck_high_recover_meas: got %0d/%0d want 10/30", last_high, last_period);
    end
    n_cmp++;
    if ({bus.stuck_high, bus.stuck_low} !== 2'b00) begin
      n_err++; $display("FAIL stuck_high_recover_flags: got %b want 00", {bus.stuck_high, bus.stuck_low});
    end
  endtask

  task automatic test_stuck_low();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    drive(1'b0, 110);
    n_cmp++;
    if ({bus.stuck_high, bus.stuck_low} !== 2'b01) begin
      n_err++; $display("FAIL stuck_low_set: got %b want 01", {bus.stuck_high, bus.stuck_low});
    end
    drive(1'b1, 10);
    n_cmp++;
    if ({bus.stuck_high, bus.stuck_low} !== 2'b00) begin
      n_err++; $display("FAIL stuck_low_clear: got %b want 00", {bus.stuck_high, bus.stuck_low});
    end
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin
      n_err++; $display("FAIL stuck_low_first_rise: got %0d want 0", strobe_cnt - s0);
    end
    drive(1'b0, 20);
    drive(1'b1, 6);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin
      n_err++; $display("FAIL stuck_low_second_rise: got %0d want 1", strobe_cnt - s0);
    end
    n_cmp++;
    if ({last_high, last_period} !== {16'd10, 16'd30}) begin
      n_err++; $display("FAIL stuck_low_meas: got %0d/%0d want 10/30", last_high, last_period);
    end
  endtask

  task automatic test_reset_mid_period();
    int s0;
    do_reset();
    drive(1'b0, 3);
    repeat (2) begin
      drive(1'b1, 15);
      drive(1'b0, 25);
    end
    drive(1'b1, 5);
    n_cmp++;
    if ({bus.high_cnt, bus.period_cnt} !== {16'd15, 16'd40}) begin
      n_err++; $display("FAIL pre_reset_meas: got %0d/%0d want 15/40", bus.high_cnt, bus.period_cnt);
    end
    rst = 1'b1;
    step(1);
    n_cmp++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %h want 0", all_out());
    end
    step(9);
    drive(1'b0, 5);
    rst = 1'b0;
    s0  = strobe_cnt;
    drive(1'b0, 20);
    drive(1'b1, 15);
    drive(1'b0, 25);
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin
      n_err++; $display("FAIL post_reset_first_rise: got %0d want 0", strobe_cnt - s0);
    end
    drive(1'b1, 6);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin
      n_err++; $display("FAIL post_reset_second_rise: got %0d want 1", strobe_cnt - s0);
    end
    n_cmp++;
    if ({last_high, last_period} !== {16'd15, 16'd40}) begin
      n_err++; $display("FAIL post_reset_meas: got %0d/%0d want 15/40", last_high, last_period);
    end
  endtask

  task automatic test_timeout_boundary();
    int s0;
    do_reset();
    drive(1'b0, 3);
    drive(1'b1, 10);
    drive(1'b0, 89);
    s0 = strobe_cnt;
    drive(1'b1, 10);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin
      n_err++; $display("FAIL p99_strobe: got %0d want 1", strobe_cnt - s0);
    end
    n_cmp++;
    if ({last_high, last_period} !== {16'd10, 16'd99}) begin
      n_err++; $display("FAIL p99_meas: got %0d/%0d want 10/99", last_high, last_period);
    end
    saw_sl = 1'b0;
    saw_sh = 1'b0;
    s0     = strobe_cnt;
    drive(1'b0, 90);
    drive(1'b1, 6);
    n_cmp++;
    if ({saw_sh, saw_sl} !== 2'b01) begin
      n_err++; $display("FAIL p100_stuck_seen: got %b want 01", {saw_sh, saw_sl});
    end
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin
      n_err++; $display("FAIL p100_no_strobe: got %0d want 0", strobe_cnt - s0);
    end
    n_cmp++;
    if (bus.period_cnt !== 16'd99) begin
      n_err++; $display("FAIL p100_period_hold: got %0d want 99", bus.period_cnt);
    end
    n_cmp++;
    if ({bus.stuck_high, bus.stuck_low} !== 2'b00) begin
      n_err++; $display("FAIL p100_flags_cleared: got %b want 00", {bus.stuck_high, bus.stuck_low});
    end
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_period_10_20();
    test_min_pulse();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid_period();
    test_timeout_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 65535: cycle count with no edge after which the input is flagged stuck; range 2..2^CNT_W-1.
REQ-003 clk  input  1  system clock (27 MHz board clock); all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-006 high_cnt  output  CNT_W  clk cycles high in the last complete period.
REQ-007 period_cnt  output  CNT_W  clk cycles between the last two rising edges.
REQ-008 meas_valid  output  1  one-cycle strobe: high_cnt/period_cnt just updated.
REQ-009 stuck_high  output  1  level flag: input held high for TIMEOUT cycles.
REQ-010 stuck_low  output  1  level flag: input held low for TIMEOUT cycles.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; s is the second flop output and s_d is s delayed one cycle.
REQ-012 Rise event SHALL be s=1 and s_d=0; fall event SHALL be s=0 and s_d=1; events are evaluated in the same cycle they occur.
REQ-013 Latency from a pwm_in transition to its event SHALL be 3 clk edges; latency is identical for rise and fall, so measured widths are unbiased.
REQ-014 State machine SHALL have states IDLE, HIGH, LOW, STUCK.
REQ-015 Run counter r SHALL be set to 1 on every rise event, otherwise incremented by 1, and saturate at TIMEOUT (no wrap).
REQ-016 IDLE: rise -> HIGH without meas_valid; fall ignored; r reaching TIMEOUT -> STUCK.
REQ-017 HIGH: fall -> LOW with the internal high latch set to the current r value (pre-increment); r reaching TIMEOUT -> STUCK.
REQ-018 LOW: rise -> HIGH, period_cnt <= r (pre-increment), high_cnt <= high latch, meas_valid=1 in the next cycle for exactly one cycle; r reaching TIMEOUT -> STUCK.
REQ-019 On entering STUCK, stuck_high SHALL be set if s=1, else stuck_low; exactly one is set.
REQ-020 STUCK: rise -> HIGH, both stuck flags cleared in the same update, no meas_valid, since the first period after a stall is incomplete; fall -> LOW, stuck_high cleared, high latch not updated.
REQ-021 high_cnt and period_cnt SHALL hold their values between strobes, including through STUCK.
REQ-022 A period equal to TIMEOUT-1 SHALL measure normally; a period reaching TIMEOUT SHALL enter STUCK instead of producing a measurement.
REQ-023 A 1-cycle synchronized high pulse SHALL yield high_cnt=1.

Reset
REQ-024 With rst=1 at a clk edge: state=IDLE, r=0, synchronizer and s_d=0, high latch=0, high_cnt=0, period_cnt=0, meas_valid=0, stuck_high=0, stuck_low=0.
REQ-025 Reset SHALL take priority over every event, including mid-period; no strobe is produced by a period that straddles reset.

Verification
REQ-026 pwm_in high 10 / low 20 cycles, repeated -> first strobe after the second rise event, then every 30 cycles; high_cnt=10, period_cnt=30.
REQ-027 pwm_in held high after a rise for TIMEOUT cycles (TIMEOUT=100 build) -> stuck_high=1, stuck_low=0, no strobe; next fall clears stuck_high; the following full period is measured.
REQ-028 pwm_in held low from reset for 100 cycles (TIMEOUT=100) -> stuck_low=1; the first rise clears it with no strobe; the second rise strobes.
REQ-029 rst asserted 5 cycles into a period 40 / high 15 stream -> all outputs 0 next cycle; first strobe after release comes after two post-reset rises, with values 15/40.
REQ-030 Period 99 then 100 (TIMEOUT=100) -> the 99 period strobes period_cnt=99; the 100 period sets the stuck flag, no strobe, and period_cnt stays 99.
